// File: rtl/cfg_loader.sv
// Serial configuration loader: shifts a captured LEN-bit word out MSB first on
// cfg/cfg_clk, then raises pal_en once the downstream chain holds the full word.
module cfg_loader #(
  parameter int LEN  = 8,
  parameter int HALF = 1
) (
  input  logic           clk,
  input  logic           res_n,
  input  logic           start,
  input  logic [LEN-1:0] data,
  input  logic           abort,
  output logic           cfg_clk,
  output logic           cfg,
  output logic           pal_en,
  output logic           busy,
  output logic           done,
  output logic [1:0]     dbg_state
);

  localparam int CW = $clog2(LEN + 1);
  localparam int HW = (HALF > 1) ? $clog2(HALF) : 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT_LO = 2'd1,
    SHIFT_HI = 2'd2,
    LOADED   = 2'd3
  } state_t;

  state_t         r_state, w_state_nx;
  logic [HW-1:0]  r_half_cnt, w_half_cnt_nx;
  logic [CW-1:0]  r_bit_cnt, w_bit_cnt_nx;
  logic [LEN-1:0] r_shadow, w_shadow_nx;
  logic           r_cfg_clk, w_cfg_clk_nx;
  logic           r_cfg, w_cfg_nx;
  logic           r_pal_en, w_pal_en_nx;
  logic           r_busy, w_busy_nx;
  logic           r_done, w_done_nx;

  logic           w_half_end;
  logic           w_bits_left;
  logic [LEN-1:0] w_shadow_shl;

  assign w_half_end   = (r_half_cnt == HW'(HALF - 1));
  // r_bit_cnt counts cfg_clk rises already issued, so it never exceeds LEN
  assign w_bits_left  = (r_bit_cnt < CW'(LEN));
  assign w_shadow_shl = r_shadow << 1;

  always_comb begin
    w_state_nx    = r_state;
    w_half_cnt_nx = r_half_cnt;
    w_bit_cnt_nx  = r_bit_cnt;
    w_shadow_nx   = r_shadow;
    w_cfg_clk_nx  = r_cfg_clk;
    w_cfg_nx      = r_cfg;
    w_pal_en_nx   = r_pal_en;
    w_busy_nx     = r_busy;
    w_done_nx     = 1'b0;
    case (r_state)
      IDLE, LOADED: begin
        if (start) begin
          w_state_nx    = SHIFT_LO;
          w_shadow_nx   = data;
          w_bit_cnt_nx  = '0;
          w_half_cnt_nx = '0;
          w_cfg_clk_nx  = 1'b0;
          w_cfg_nx      = data[LEN-1];
          w_pal_en_nx   = 1'b0;
          w_busy_nx     = 1'b1;
        end
      end
      SHIFT_LO: begin
        if (abort) begin
          w_state_nx    = IDLE;
          w_half_cnt_nx = '0;
          w_bit_cnt_nx  = '0;
          w_cfg_clk_nx  = 1'b0;
          w_cfg_nx      = 1'b0;
          w_pal_en_nx   = 1'b0;
          w_busy_nx     = 1'b0;
        end else if (w_half_end) begin
          w_state_nx    = SHIFT_HI;
          w_half_cnt_nx = '0;
          w_bit_cnt_nx  = r_bit_cnt + 1'b1;
          w_cfg_clk_nx  = 1'b1;
        end else begin
          w_half_cnt_nx = r_half_cnt + 1'b1;
        end
      end
      SHIFT_HI: begin
        // abort wins over the final exit, so a cancelled load never pulses done
        if (abort) begin
          w_state_nx    = IDLE;
          w_half_cnt_nx = '0;
          w_bit_cnt_nx  = '0;
          w_cfg_clk_nx  = 1'b0;
          w_cfg_nx      = 1'b0;
          w_pal_en_nx   = 1'b0;
          w_busy_nx     = 1'b0;
        end else if (w_half_end) begin
          w_half_cnt_nx = '0;
          w_cfg_clk_nx  = 1'b0;
          if (w_bits_left) begin
            w_state_nx  = SHIFT_LO;
            w_shadow_nx = w_shadow_shl;
            w_cfg_nx    = w_shadow_shl[LEN-1];
          end else begin
            w_state_nx  = LOADED;
            w_cfg_nx    = 1'b0;
            w_pal_en_nx = 1'b1;
            w_busy_nx   = 1'b0;
            w_done_nx   = 1'b1;
          end
        end else begin
          w_half_cnt_nx = r_half_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_state    <= IDLE;
      r_half_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shadow   <= '0;
      r_cfg_clk  <= 1'b0;
      r_cfg      <= 1'b0;
      r_pal_en   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_half_cnt <= w_half_cnt_nx;
      r_bit_cnt  <= w_bit_cnt_nx;
      r_shadow   <= w_shadow_nx;
      r_cfg_clk  <= w_cfg_clk_nx;
      r_cfg      <= w_cfg_nx;
      r_pal_en   <= w_pal_en_nx;
      r_busy     <= w_busy_nx;
      r_done     <= w_done_nx;
    end
  end

  assign cfg_clk   = r_cfg_clk;
  assign cfg       = r_cfg;
  assign pal_en    = r_pal_en;
  assign busy      = r_busy;
  assign done      = r_done;
  assign dbg_state = r_state;

endmodule
